// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the HD44780-style LCD controller: FSM states, init bytes and helpers.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    SETUP,
    PULSE,
    WAIT,
    IDLE
  } state_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;

  localparam int unsigned INIT_LEN = 4;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = LCD_FUNC_SET;
      2'd1:    init_byte = LCD_DISP_ON;
      2'd2:    init_byte = LCD_ENTRY;
      default: init_byte = LCD_CLEAR;
    endcase
  endfunction

  // A zero-length delay would never raise done, so it is stretched to one cycle.
  function automatic int unsigned at_least_one(input int unsigned cyc);
    return (cyc == 0) ? 1 : cyc;
  endfunction

  // Clear and home need the long execution wait; only as commands, not as characters.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: start loads a length N (N >= 1), done is high on the Nth cycle after.
module lcd_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done,
  output logic         idle
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));
  assign idle = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD sequencer: power-up delay, fixed init sequence, then
// command/data writes accepted over a valid/ready handshake.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned POWERUP_CYC  = 1_000_000,
  parameter int unsigned EN_PULSE_CYC = 50,
  parameter int unsigned CMD_WAIT_CYC = 2_500,
  parameter int unsigned CLR_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned PWR_LEN = at_least_one(POWERUP_CYC);
  localparam int unsigned EN_LEN  = at_least_one(EN_PULSE_CYC);
  localparam int unsigned CMD_LEN = at_least_one(CMD_WAIT_CYC);
  localparam int unsigned CLR_LEN = at_least_one(CLR_WAIT_CYC);
  localparam int unsigned MAX_A   = (PWR_LEN > EN_LEN)  ? PWR_LEN : EN_LEN;
  localparam int unsigned MAX_B   = (CMD_LEN > CLR_LEN) ? CMD_LEN : CLR_LEN;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned W       = $clog2(MAX_CYC + 1);

  state_t       state, next_state;
  logic [1:0]   idx, idx_next;
  logic         cap_rs;
  logic [7:0]   cap_data;
  logic         done_next;
  logic         tmr_start;
  logic [W-1:0] tmr_load;
  logic         tmr_done;
  logic         tmr_idle;

  lcd_delay_timer #(
    .W(W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(tmr_start),
    .load (tmr_load),
    .done (tmr_done),
    .idle (tmr_idle)
  );

  always_comb begin
    next_state = state;
    idx_next   = idx;
    cap_rs     = lcd_rs;
    cap_data   = lcd_data;
    done_next  = init_done;
    tmr_start  = 1'b0;
    tmr_load   = '0;
    case (state)
      PWRUP: begin
        // Reset clears the timer, so the first PWRUP cycle arms it before counting.
        if (tmr_idle) begin
          tmr_start = 1'b1;
          tmr_load  = W'(PWR_LEN);
        end else if (tmr_done) begin
          next_state = SETUP;
          cap_rs     = 1'b0;
          cap_data   = init_byte(idx);
        end
      end
      SETUP: begin
        next_state = PULSE;
        tmr_start  = 1'b1;
        tmr_load   = W'(EN_LEN);
      end
      PULSE: begin
        if (tmr_done) begin
          next_state = WAIT;
          tmr_start  = 1'b1;
          tmr_load   = is_long_cmd(lcd_rs, lcd_data) ? W'(CLR_LEN) : W'(CMD_LEN);
        end
      end
      WAIT: begin
        if (tmr_done) begin
          if (init_done) begin
            next_state = IDLE;
          end else if (idx == 2'(INIT_LEN - 1)) begin
            done_next  = 1'b1;
            next_state = IDLE;
          end else begin
            idx_next   = idx + 2'd1;
            cap_rs     = 1'b0;
            cap_data   = init_byte(idx + 2'd1);
            next_state = SETUP;
          end
        end
      end
      IDLE: begin
        if (req_valid) begin
          cap_rs     = req_rs;
          cap_data   = req_data;
          next_state = SETUP;
        end
      end
      default: next_state = PWRUP;
    endcase
  end

  // Strobe and ready are registered from next_state so they track the state cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      idx       <= '0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      lcd_en    <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= idx_next;
      lcd_rs    <= cap_rs;
      lcd_data  <= cap_data;
      lcd_en    <= (next_state == PULSE);
      req_ready <= (next_state == IDLE);
      init_done <= done_next;
    end
  end

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with shortened delays.
module tb_lcd_ctrl;

  localparam int unsigned P_CYC   = 20;
  localparam int unsigned EN_CYC  = 3;
  localparam int unsigned CMD_CYC = 10;
  localparam int unsigned CLR_CYC = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .POWERUP_CYC (P_CYC),
    .EN_PULSE_CYC(EN_CYC),
    .CMD_WAIT_CYC(CMD_CYC),
    .CLR_WAIT_CYC(CLR_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rw_bad = 0;
  int stab_bad = 0;

  int         rise_cyc[$];
  int         fall_cyc[$];
  int         ready_cyc[$];
  int         done_cyc[$];
  logic [7:0] rise_data[$];
  logic       rise_rs[$];

  logic       prev_en = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (lcd_rw !== 1'b0) rw_bad++;
    if (lcd_en === 1'b1 && prev_en && (lcd_data !== prev_data || lcd_rs !== prev_rs)) stab_bad++;
    if (lcd_en === 1'b1 && !prev_en) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(lcd_data);
      rise_rs.push_back(lcd_rs);
    end
    if (lcd_en !== 1'b1 && prev_en) fall_cyc.push_back(cyc);
    if (req_ready === 1'b1 && !prev_ready) ready_cyc.push_back(cyc);
    if (init_done === 1'b1 && !prev_done) done_cyc.push_back(cyc);
    prev_en    = (lcd_en === 1'b1);
    prev_ready = (req_ready === 1'b1);
    prev_done  = (init_done === 1'b1);
    prev_rs    = lcd_rs;
    prev_data  = lcd_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    fall_cyc.delete();
    ready_cyc.delete();
    done_cyc.delete();
    rise_data.delete();
    rise_rs.delete();
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (req_ready !== 1'b1) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic rs, input logic [7:0] data, input string tag, output int acc);
    tick();
    wait_ready(tag);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    acc       = cyc + 1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_wait(input string tag, input int exp);
    if (fall_cyc.size() >= 1 && ready_cyc.size() >= 1)
      check(tag, ready_cyc[0] - fall_cyc[0], exp);
    else
      check({tag, "_missing"}, 0, 1);
  endtask

  task automatic check_init(input string pfx);
    int k = 0;
    while (init_done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    settle();
    check({pfx, "_init_done"}, init_done, 1);
    check({pfx, "_ready"}, req_ready, 1);
    check({pfx, "_n_pulses"}, rise_cyc.size(), 4);
    check({pfx, "_n_ready_rise"}, ready_cyc.size(), 1);
    if (rise_cyc.size() == 4 && fall_cyc.size() == 4 && ready_cyc.size() >= 1 && done_cyc.size() >= 1) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_data%0d", pfx, i), rise_data[i], init_exp[i]);
        check($sformatf("%s_rs%0d", pfx, i), rise_rs[i], 0);
        check($sformatf("%s_width%0d", pfx, i), fall_cyc[i] - rise_cyc[i], EN_CYC);
      end
      for (int i = 0; i < 3; i++)
        check($sformatf("%s_gap%0d", pfx, i), rise_cyc[i+1] - fall_cyc[i], 1 + CMD_CYC);
      check({pfx, "_ready_after_clear"}, ready_cyc[0] - fall_cyc[3], CLR_CYC);
      check({pfx, "_done_after_clear"}, done_cyc[0] - fall_cyc[3], CLR_CYC);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;

    // Reset state
    tick(); tick(); tick();
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_ready", req_ready, 0);
    check("rst_done", init_done, 0);
    clear_log();
    rst = 1'b0;

    // 1: init sequence
    check_init("t1");

    // 2: single character write
    clear_log();
    send(1'b1, 8'h41, "t2", acc);
    wait_ready("t2");
    settle();
    check("t2_n_pulses", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1 && fall_cyc.size() == 1) begin
      check("t2_latency", rise_cyc[0] - acc, 2);
      check("t2_data", rise_data[0], 8'h41);
      check("t2_rs", rise_rs[0], 1);
      check("t2_width", fall_cyc[0] - rise_cyc[0], EN_CYC);
    end
    check("t2_n_ready_rise", ready_cyc.size(), 1);
    check_wait("t2_wait", CMD_CYC);

    // 3: back-to-back with valid held
    clear_log();
    tick();
    wait_ready("t3a");
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    tick();
    req_data  = 8'h49;
    wait_ready("t3b");
    tick();
    req_valid = 1'b0;
    wait_ready("t3c");
    settle();
    check("t3_n_pulses", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      check("t3_data0", rise_data[0], 8'h48);
      check("t3_data1", rise_data[1], 8'h49);
      check("t3_spacing", rise_cyc[1] - rise_cyc[0], 1 + 1 + EN_CYC + CMD_CYC);
    end

    // 4: home command gets the long wait, home as a character does not
    clear_log();
    send(1'b0, 8'h02, "t4a", acc);
    wait_ready("t4a");
    settle();
    check_wait("t4_home_cmd_wait", CLR_CYC);
    clear_log();
    send(1'b1, 8'h02, "t4b", acc);
    wait_ready("t4b");
    settle();
    check_wait("t4_home_char_wait", CMD_CYC);

    // 6: request during WAIT is ignored
    clear_log();
    send(1'b1, 8'h55, "t6", acc);
    k = 0;
    while (fall_cyc.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    check("t6_in_wait", fall_cyc.size(), 1);
    req_valid = 1'b1;
    req_rs    = 1'b0;
    req_data  = 8'h5A;
    tick();
    req_valid = 1'b0;
    check("t6_data_held", lcd_data, 8'h55);
    wait_ready("t6");
    settle();
    check("t6_data_idle", lcd_data, 8'h55);
    check("t6_rs_idle", lcd_rs, 1);
    check("t6_n_pulses", rise_cyc.size(), 1);
    check_wait("t6_wait", CMD_CYC);
    clear_log();
    send(1'b1, 8'h43, "t6b", acc);
    wait_ready("t6b");
    settle();
    check("t6_next_pulses", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1) check("t6_next_data", rise_data[0], 8'h43);

    // 5: reset during the enable pulse restarts everything
    send(1'b1, 8'h77, "t5", acc);
    k = 0;
    while (lcd_en !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("t5_in_pulse", lcd_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_en", lcd_en, 0);
    check("t5_ready", req_ready, 0);
    check("t5_done", init_done, 0);
    check("t5_data", lcd_data, 8'h00);
    settle();
    clear_log();
    check_init("t5");

    check("rw_low", rw_bad, 0);
    check("en_stable", stab_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
